// File: rtl/fsm_countdown.sv
// Hour/minute/second countdown timer: loads a clamped preset, decrements once per
// prescaled tick with borrow propagation, and flags expiry at 00:00:00.
module fsm_countdown #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_in,
    input  logic       start_in,
    input  logic       pause_in,
    input  logic [5:0] sec_in,
    input  logic [5:0] min_in,
    input  logic [5:0] hour_in,
    output logic [5:0] sec_out,
    output logic [5:0] min_out,
    output logic [5:0] hour_out,
    output logic       busy,
    output logic       done,
    output logic       expired
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0] PRESC_MAX = 16'(TICK_DIV - 1);

    state_t      state_q, state_d;
    logic [5:0]  sec_q, sec_d;
    logic [5:0]  min_q, min_d;
    logic [5:0]  hour_q, hour_d;
    logic [15:0] presc_q, presc_d;
    logic        done_q, done_d;
    logic        tick;
    logic        at_zero;
    logic        at_one;
    logic        go;

    assign at_zero = (sec_q == 6'd0) && (min_q == 6'd0) && (hour_q == 6'd0);
    assign at_one  = (sec_q == 6'd1) && (min_q == 6'd0) && (hour_q == 6'd0);
    // A pause request always wins over a start request in the same cycle.
    assign go      = start_in && !pause_in;
    assign tick    = (state_q == RUN) && !load_in && !pause_in && (presc_q == PRESC_MAX);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            sec_q   <= 6'd0;
            min_q   <= 6'd0;
            hour_q  <= 6'd0;
            presc_q <= 16'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            presc_q <= presc_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (load_in) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (go) state_d = at_zero ? DONE : RUN;
                RUN: begin
                    if (pause_in)            state_d = PAUSE;
                    else if (tick && at_one) state_d = DONE;
                end
                PAUSE:   if (go) state_d = RUN;
                DONE:    state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        presc_d = presc_q;
        if (load_in) begin
            sec_d   = (sec_in  > 6'd59) ? 6'd59 : sec_in;
            min_d   = (min_in  > 6'd59) ? 6'd59 : min_in;
            hour_d  = (hour_in > 6'd23) ? 6'd23 : hour_in;
            presc_d = 16'd0;
        end else if (state_q == RUN && !pause_in) begin
            presc_d = tick ? 16'd0 : presc_q + 16'd1;
            // Hour never borrows below zero: the 00:00:01 tick ends the run first.
            if (tick) begin
                if (sec_q != 6'd0) begin
                    sec_d = sec_q - 6'd1;
                end else begin
                    sec_d = 6'd59;
                    if (min_q != 6'd0) begin
                        min_d = min_q - 6'd1;
                    end else begin
                        min_d  = 6'd59;
                        hour_d = hour_q - 6'd1;
                    end
                end
            end
        end
        done_d = (state_d == DONE) && (state_q != DONE);
    end

    always_comb begin
        busy     = (state_q == RUN);
        expired  = (state_q == DONE);
        done     = done_q;
        sec_out  = sec_q;
        min_out  = min_q;
        hour_out = hour_q;
    end

endmodule
